// File: rtl/count_repeat_seq_pkg.sv
// Shared types and the repeat-count rule
// for the count/repeat sequence generator.
package count_repeat_seq_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    typedef enum logic {
        MODE_VALUE = 1'b0,
        MODE_FIXED = 1'b1
    } mode_t;

    // R(v): value itself or the fixed count, never below 1.
    function automatic logic [31:0] rep_of(
        input logic [31:0] v,
        input mode_t       mode,
        input logic [31:0] rep
    );
        logic [31:0] r;
        r = (mode == MODE_FIXED) ? rep : v;
        return (r == 32'd0) ? 32'd1 : r;
    endfunction

endpackage

// File: rtl/count_repeat_seq_rep_ctr.sv
// Repeat counter: counts 1..rmax for the value
// currently on the output, flags the terminal count.
module count_repeat_seq_rep_ctr
    import count_repeat_seq_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         adv,
    input  logic [W-1:0] rmax,
    output logic [W-1:0] rep,
    output logic         tc
);

    // adv is only issued below the terminal count, so no wrap.
    assign tc = (rep == rmax);

    // Load restarts at 1, advance steps by one.
    always_ff @(posedge clk) begin
        if (rst) begin
            rep <= '0;
        end else if (load) begin
            rep <= W'(1);
        end else if (adv) begin
            rep <= rep + W'(1);
        end
    end

endmodule

// File: rtl/count_repeat_seq.sv
// Sequence generator: emits first..last, each value
// repeated R(v) times, on a valid/ready stream.
module count_repeat_seq
    import count_repeat_seq_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         stop,
    input  logic [W-1:0] cfg_first,
    input  logic [W-1:0] cfg_last,
    input  logic         cfg_mode,
    input  logic [W-1:0] cfg_rep,
    input  logic         cfg_loop,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_value,
    output logic         out_last,
    output logic         busy,
    output logic         done,
    output logic         cfg_err
);

    state_t       state;
    logic [W-1:0] value;
    logic [W-1:0] first_q;
    logic [W-1:0] last_q;
    logic [W-1:0] rep_q;
    mode_t        mode_q;
    logic         loop_q;
    logic         stop_pend;

    logic [W-1:0] rep;
    logic [W-1:0] r_cur;
    logic         tc;
    logic         xfer;
    logic         at_last;
    logic         eos;
    logic         finish;
    logic         start_ok;
    logic         ctr_load;
    logic         ctr_adv;

    assign out_valid = (state == RUN);
    assign busy      = out_valid;
    assign out_value = value;

    assign r_cur = W'(rep_of(32'(value), mode_q, 32'(rep_q)));

    assign xfer     = out_valid & out_ready;
    assign at_last  = (value == last_q);
    assign out_last = out_valid & at_last & tc;
    assign eos      = xfer & tc & at_last;
    // A stop arriving with the final beat still ends the loop.
    assign finish   = eos & (~loop_q | stop_pend | stop);
    assign start_ok = (state == IDLE) & start
                    & (cfg_first <= cfg_last);
    assign ctr_load = start_ok | (xfer & tc);
    assign ctr_adv  = xfer & ~tc;

    count_repeat_seq_rep_ctr #(
        .W (W)
    ) u_rep_ctr (
        .clk  (clk),
        .rst  (rst),
        .load (ctr_load),
        .adv  (ctr_adv),
        .rmax (r_cur),
        .rep  (rep),
        .tc   (tc)
    );

    // FSM, status pulses and the sticky stop request.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            done      <= 1'b0;
            cfg_err   <= 1'b0;
            stop_pend <= 1'b0;
        end else begin
            done    <= finish;
            cfg_err <= (state == IDLE) & start
                     & (cfg_first > cfg_last);
            if (start_ok) begin
                state <= RUN;
            end else if (finish) begin
                state <= IDLE;
            end
            if ((state == IDLE) || finish) begin
                stop_pend <= 1'b0;
            end else if (stop) begin
                stop_pend <= 1'b1;
            end
        end
    end

    // Configuration snapshot taken on an accepted start.
    always_ff @(posedge clk) begin
        if (rst) begin
            first_q <= '0;
            last_q  <= '0;
            rep_q   <= '0;
            mode_q  <= MODE_VALUE;
            loop_q  <= 1'b0;
        end else if (start_ok) begin
            first_q <= cfg_first;
            last_q  <= cfg_last;
            rep_q   <= cfg_rep;
            mode_q  <= mode_t'(cfg_mode);
            loop_q  <= cfg_loop;
        end
    end

    // Value register: compare with last before stepping,
    // so last = all-ones never wraps.
    always_ff @(posedge clk) begin
        if (rst) begin
            value <= '0;
        end else if (start_ok) begin
            value <= cfg_first;
        end else if (xfer & tc) begin
            if (!at_last) begin
                value <= value + W'(1);
            end else if (!finish) begin
                value <= first_q;
            end
        end
    end

endmodule

// File: tb/tb_count_repeat_seq.sv
// Self-checking bench for count_repeat_seq:
// scoreboard of expected beats, one task per scenario.
module tb_count_repeat_seq;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         stop;
    logic [W-1:0] cfg_first;
    logic [W-1:0] cfg_last;
    logic         cfg_mode;
    logic [W-1:0] cfg_rep;
    logic         cfg_loop;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_value;
    logic         out_last;
    logic         busy;
    logic         done;
    logic         cfg_err;

    int errors = 0;
    int checks = 0;

    logic [W:0] exp_q[$];

    count_repeat_seq #(
        .W (W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .stop      (stop),
        .cfg_first (cfg_first),
        .cfg_last  (cfg_last),
        .cfg_mode  (cfg_mode),
        .cfg_rep   (cfg_rep),
        .cfg_loop  (cfg_loop),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_value (out_value),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done),
        .cfg_err   (cfg_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Expected beats {last, value} for one pass.
    task automatic push_seq(input int first, input int last,
                            input int mode, input int rep);
        for (int v = first; v <= last; v++) begin
            int r;
            logic lb;
            if (mode != 0) r = (rep == 0) ? 1 : rep;
            else           r = (v == 0) ? 1 : v;
            for (int k = 1; k <= r; k++) begin
                lb = (v == last) && (k == r);
                exp_q.push_back({lb, W'(v)});
            end
        end
    endtask

    task automatic start_run(input int first, input int last,
                             input int mode, input int rep,
                             input int loop);
        @(negedge clk);
        cfg_first = W'(first);
        cfg_last  = W'(last);
        cfg_mode  = mode[0];
        cfg_rep   = W'(rep);
        cfg_loop  = loop[0];
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL start_latency: out_valid=%b required 1",
                     out_valid);
        end
    endtask

    // Consume beats until the scoreboard empties.
    task automatic drain(input int low_pct, input int stop_at,
                         input int max_cyc);
        int beats = 0;
        int cyc = 0;
        bit fin = 0;
        logic pv = 1'b0;
        logic pr = 1'b0;
        logic [W-1:0] pval = '0;
        logic plast = 1'b0;
        logic [W:0] e;
        while (!fin && cyc < max_cyc) begin
            out_ready = ($urandom_range(0, 99) >= low_pct);
            stop = (beats == stop_at);
            if (pv && !pr) begin
                checks++;
                if (out_valid !== 1'b1 || out_value !== pval
                    || out_last !== plast) begin
                    errors++;
                    $display("FAIL stall_hold: v=%b val=%0d l=%b required v=1 val=%0d l=%b",
                             out_valid, out_value, out_last, pval, plast);
                end
            end
            if (low_pct == 0) begin
                checks++;
                if (out_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL no_gap: out_valid=%b required 1 at beat %0d",
                             out_valid, beats);
                end
            end
            if (out_valid === 1'b1 && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL extra_beat: val=%0d required none",
                             out_value);
                    fin = 1;
                end else begin
                    e = exp_q.pop_front();
                    if ({out_last, out_value} !== e) begin
                        errors++;
                        $display("FAIL beat%0d: val=%0d last=%b required val=%0d last=%b",
                                 beats, out_value, out_last,
                                 e[W-1:0], e[W]);
                    end
                    beats++;
                    if (exp_q.size() == 0) fin = 1;
                end
            end
            pv = out_valid;
            pr = out_ready;
            pval = out_value;
            plast = out_last;
            @(negedge clk);
            cyc++;
        end
        stop = 1'b0;
        if (!fin) begin
            errors++;
            checks++;
            $display("FAIL drain_timeout: %0d beats left required 0",
                     exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic check_end();
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL end_state: done=%b busy=%b valid=%b required 1 0 0",
                     done, busy, out_valid);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL done_pulse: done=%b required 0", done);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({out_valid, out_value, out_last, busy, done, cfg_err}
            !== '0) begin
            errors++;
            $display("FAIL reset: v=%b val=%0d l=%b busy=%b done=%b err=%b required all 0",
                     out_valid, out_value, out_last, busy, done, cfg_err);
        end
        rst = 1'b0;
    endtask

    task automatic test_value_mode();
        start_run(0, 4, 0, 0, 0);
        push_seq(0, 4, 0, 0);
        drain(0, -1, 40);
        check_end();
    endtask

    task automatic test_fixed_mode();
        start_run(5, 6, 1, 3, 0);
        push_seq(5, 6, 1, 3);
        drain(0, -1, 30);
        check_end();
        start_run(5, 6, 1, 0, 0);
        push_seq(5, 6, 1, 0);
        drain(0, -1, 30);
        check_end();
    endtask

    task automatic test_random_ready();
        for (int i = 0; i < 3; i++) begin
            start_run(0, 4, 0, 0, 0);
            push_seq(0, 4, 0, 0);
            drain(40, -1, 400);
            check_end();
        end
    endtask

    task automatic test_max();
        start_run(15, 15, 0, 0, 0);
        push_seq(15, 15, 0, 0);
        drain(0, -1, 40);
        check_end();
    endtask

    task automatic test_loop_stop();
        start_run(1, 2, 0, 0, 1);
        push_seq(1, 2, 0, 0);
        push_seq(1, 2, 0, 0);
        drain(0, 4, 40);
        check_end();
        start_run(1, 2, 0, 0, 1);
        push_seq(1, 2, 0, 0);
        drain(0, 2, 40);
        check_end();
    endtask

    task automatic test_start_busy();
        out_ready = 1'b0;
        start_run(0, 2, 0, 0, 0);
        push_seq(0, 2, 0, 0);
        cfg_first = 4'd9;
        cfg_last  = 4'd12;
        cfg_mode  = 1'b1;
        cfg_rep   = 4'd5;
        cfg_loop  = 1'b1;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || out_value !== 4'd0) begin
            errors++;
            $display("FAIL start_busy: busy=%b val=%0d required 1 0",
                     busy, out_value);
        end
        drain(0, -1, 30);
        check_end();
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b1;
        start_run(0, 4, 0, 0, 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({out_valid, out_value, out_last, busy, done} !== '0) begin
            errors++;
            $display("FAIL reset_mid: v=%b val=%0d l=%b busy=%b done=%b required all 0",
                     out_valid, out_value, out_last, busy, done);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_no_done: done=%b busy=%b required 0 0",
                     done, busy);
        end
    endtask

    task automatic test_cfg_err();
        @(negedge clk);
        cfg_first = 4'd7;
        cfg_last  = 4'd3;
        cfg_mode  = 1'b0;
        cfg_loop  = 1'b0;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (cfg_err !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL cfg_err: err=%b v=%b busy=%b required 1 0 0",
                     cfg_err, out_valid, busy);
        end
        @(negedge clk);
        checks++;
        if (cfg_err !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL cfg_err_pulse: err=%b v=%b required 0 0",
                     cfg_err, out_valid);
        end
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        stop      = 1'b0;
        cfg_first = '0;
        cfg_last  = '0;
        cfg_mode  = 1'b0;
        cfg_rep   = '0;
        cfg_loop  = 1'b0;
        out_ready = 1'b1;
        test_reset();
        test_value_mode();
        test_fixed_mode();
        test_random_ready();
        test_max();
        test_loop_stop();
        test_start_busy();
        test_reset_mid();
        test_cfg_err();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/count_repeat_seq.md
Name: count_repeat_seq

Overview:
- Parametrised sequence generator. Emits values first..last; each value v is repeated a mode-dependent number of times.
  - Value mode: v is repeated v times (0 and 1 emitted once).
  - Fixed mode: every value is repeated cfg_rep times.
- Output is a valid/ready stream with end-of-sequence marker, optional continuous looping and graceful stop.
- Sits as a stimulus/pattern source feeding downstream datapath or test logic.

Parameters:
- W, 8, width of values and repeat counts (W >= 2)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- start  in  1  pulse: latch cfg_* and begin sequence (ignored while busy)
- stop  in  1  pulse: end loop at the next sequence boundary
- cfg_first  in  W  first value
- cfg_last  in  W  last value
- cfg_mode  in  1  0 = repeat count is value, 1 = fixed repeat cfg_rep
- cfg_rep  in  W  fixed repeat count (0 treated as 1)
- cfg_loop  in  1  1 = restart at cfg_first after last beat
- out_valid  out  1  beat valid
- out_ready  in  1  downstream accept
- out_value  out  W  current value
- out_last  out  1  final beat of a sequence pass
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse, sequence finished
- cfg_err  out  1  one-cycle pulse, start rejected (cfg_first > cfg_last)

Behaviour:
- Reset: state IDLE; out_valid, out_value, out_last, busy, done, cfg_err, stop-pending all 0.
- Reset mid-run aborts immediately, with no done pulse.
- States: IDLE, RUN. Transitions:
  - IDLE -> RUN on start with cfg_first <= cfg_last.
  - RUN -> IDLE after last beat accepted, when loop = 0 or stop is pending.
- Config latched on accepted start. cfg_* changes during RUN have no effect.
- start with cfg_first > cfg_last: stay IDLE; cfg_err = 1 next cycle.
- start during RUN: ignored.
- Latency: out_valid = 1 the cycle after accepted start, out_value = cfg_first.
- Repeat count: R(v) = max(v,1) in mode 0, max(cfg_rep,1) in mode 1.
- Beat transfer = out_valid & out_ready. Internal rep counter counts 1..R(v):
  - Transfer with rep == R(v) and v != last: value <= v+1, rep <= 1.
  - Otherwise: rep <= rep+1.
- While out_valid & !out_ready: out_value, out_last and out_valid hold stable.
- out_valid is never withdrawn without a transfer.
- out_last = 1 exactly when out_value == last and rep == R(last).
- End of sequence (transfer with out_last):
  - loop = 0 or stop pending: next cycle state IDLE, out_valid = 0, done = 1 for one cycle.
  - loop = 1 and no stop: next cycle out_value = first, rep = 1. No bubble cycle.
- stop: sets a sticky pending flag during RUN, cleared on IDLE entry. stop in IDLE is ignored.
  - stop in the same cycle as the out_last transfer counts as pending.
- Width and wrap rules:
  - Never increment past last. The v == last compare happens before increment, so last = 2^W-1 does not wrap.
  - The rep counter is W bits and must handle R = 2^W-1 with no overflow.
- Throughput: one beat per cycle when out_ready is held at 1.
- Total beats per pass = sum of R(v) for v in first..last.

Decomposition:
- Package count_repeat_seq_pkg: state_t enum {IDLE, RUN}; mode_t enum {MODE_VALUE, MODE_FIXED}; function rep_of(v, mode, rep) returning R(v).
- One sub-module is natural: count_repeat_seq_rep_ctr, the repeat counter with load/advance/terminal-count.
- FSM, value register and handshake stay in the top.

Test Plan:
- W=4, first=0, last=4, mode 0, ready=1 -> stream 0,1,2,2,3,3,3,4,4,4,4 (11 beats). out_last on the 11th beat; done the cycle after; busy low after that.
- mode 1, cfg_rep=3, first=5, last=6 -> 5,5,5,6,6,6. Repeat with cfg_rep=0 -> 5,6.
- Run case 1 with random out_ready (~40% low) -> identical value sequence. Value and last stable during stalls; no dropped or duplicated beats.
- W=4, first=last=15, mode 0 -> 15 emitted 15 times with out_last on the 15th beat; no wrap to 0; done pulse.
- loop=1, first=1, last=2, mode 0 -> 1,2,2,1,2,2,... with no gap. Assert stop mid-pass -> current pass completes, then done.
- rst asserted mid-RUN -> outputs 0 next cycle, no done. start with first=7, last=3 -> cfg_err pulse, no out_valid. start during RUN -> ignored.
